// File: rtl/layer_lif_seq.sv
// Sequential leaky integrate-and-fire layer: one neuron at a time, CH weight lanes per cycle,
// membrane voltages held locally, per-neuron result streamed on out_valid.
module layer_lif_seq #(
    parameter int unsigned CH           = 4,
    parameter int unsigned WEIGHT       = 8,
    parameter int unsigned FAN_IN_WORDS = 2,
    parameter int unsigned NEURON       = 4,
    parameter int unsigned WIDTH        = 16,
    parameter int          LEAK         = 0,
    parameter int          THRESHOLD    = 100,
    localparam int unsigned DEPTH = NEURON * FAN_IN_WORDS,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned NW    = (NEURON > 1) ? $clog2(NEURON) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CH*FAN_IN_WORDS-1:0]    spikes_in,
    input  logic                          clear_state,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [CH*WEIGHT-1:0]          wr_data,
    output logic                          wr_err,
    output logic                          busy,
    output logic                          done,
    output logic                          out_valid,
    output logic                          out_spike,
    output logic [NW-1:0]                 out_idx,
    output logic signed [WIDTH-1:0]       out_voltage
);

    localparam int unsigned ACCW = WEIGHT + $clog2(CH * FAN_IN_WORDS) + 1;
    localparam int unsigned PW   = WIDTH + ACCW + 14;
    localparam int unsigned PHW  = $clog2(FAN_IN_WORDS + 1);
    localparam int unsigned WW   = (FAN_IN_WORDS > 1) ? $clog2(FAN_IN_WORDS) : 1;

    localparam logic signed [PW-1:0]    LEAK_S  = PW'(LEAK);
    localparam logic signed [WIDTH-1:0] THR     = WIDTH'(THRESHOLD);
    localparam logic signed [PW-1:0]    VMAX    = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    VMIN    = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [AW:0]             DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [PHW-1:0]          LAST_PH = PHW'(FAN_IN_WORDS);

    typedef enum logic [1:0] {IDLE, ACC, UPDATE, DONE} state_t;

    state_t                      state_q, state_d;
    logic [CH*WEIGHT-1:0]        ram [DEPTH];
    logic [CH*WEIGHT-1:0]        rdata;
    logic [AW-1:0]               addr_base, rd_addr;
    logic [PHW-1:0]              phase;
    logic [NW-1:0]               nidx;
    logic                        rd_vld;
    logic [WW-1:0]               rd_word;
    logic [CH*FAN_IN_WORDS-1:0]  spk_q;
    logic [CH-1:0]               spk_words [FAN_IN_WORDS];
    logic signed [ACCW-1:0]      acc, acc_d, contrib;
    logic signed [WIDTH-1:0]     volt [NEURON];
    logic signed [PW-1:0]        vx, prod, v_full, v_clamp;
    logic signed [WIDTH-1:0]     v_sat;
    logic                        fire, issue, last_acc;

    for (genvar g = 0; g < FAN_IN_WORDS; g++) begin : g_spk
        assign spk_words[g] = spk_q[g*CH +: CH];
    end

    // ACC spends FAN_IN_WORDS issue cycles plus one cycle to absorb the last read
    always_comb begin
        issue    = (state_q == ACC) && (phase < LAST_PH);
        last_acc = (state_q == ACC) && (phase == LAST_PH);
        rd_addr  = addr_base + AW'(phase);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACC;
            ACC:     if (last_acc) state_d = UPDATE;
            UPDATE:  state_d = (nidx == NW'(NEURON - 1)) ? DONE : ACC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Weight RAM keeps its contents through reset
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < DEPTH_C))
            ram[wr_addr] <= wr_data;
        if (issue)
            rdata <= ram[rd_addr];
    end

    // Spike-gated lane sum of the word returned by the RAM this cycle
    always_comb begin
        contrib = '0;
        for (int k = 0; k < CH; k++) begin
            if (spk_words[rd_word][k])
                contrib = contrib + ACCW'($signed(rdata[k*WEIGHT +: WEIGHT]));
        end
        acc_d = (phase == '0) ? '0 : acc;
        if (rd_vld)
            acc_d = acc_d + contrib;
    end

    // Leak, integrate and clamp, evaluated as the final word lands
    always_comb begin
        vx     = PW'(volt[nidx]);
        prod   = vx * LEAK_S;
        v_full = vx - (prod >>> 12) + PW'(acc_d);
        if (v_full > VMAX)      v_clamp = VMAX;
        else if (v_full < VMIN) v_clamp = VMIN;
        else                    v_clamp = v_full;
        v_sat = WIDTH'(v_clamp);
        fire  = (v_sat >= THR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
            out_valid   <= 1'b0;
            out_spike   <= 1'b0;
            out_idx     <= '0;
            out_voltage <= '0;
            rd_vld      <= 1'b0;
            rd_word     <= '0;
            spk_q       <= '0;
            nidx        <= '0;
            phase       <= '0;
            addr_base   <= '0;
            acc         <= '0;
            for (int i = 0; i < NEURON; i++) volt[i] <= '0;
        end else begin
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
            wr_err    <= wr_en && (state_q != IDLE);
            out_valid <= last_acc;
            rd_vld    <= issue;
            rd_word   <= WW'(phase);
            if (last_acc) begin
                out_idx     <= nidx;
                out_voltage <= v_sat;
                out_spike   <= fire;
                volt[nidx]  <= fire ? '0 : v_sat;
            end
            case (state_q)
                IDLE: begin
                    if (clear_state)
                        for (int i = 0; i < NEURON; i++) volt[i] <= '0;
                    if (start) begin
                        spk_q     <= spikes_in;
                        nidx      <= '0;
                        phase     <= '0;
                        addr_base <= '0;
                        acc       <= '0;
                    end
                end
                ACC: begin
                    acc <= acc_d;
                    if (!last_acc) phase <= phase + PHW'(1);
                end
                UPDATE: begin
                    phase     <= '0;
                    nidx      <= nidx + NW'(1);
                    addr_base <= addr_base + AW'(FAN_IN_WORDS);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_lif_seq.sv
// Scoreboard bench for layer_lif_seq: two instances (no leak / half leak) share stimulus and are
// checked against an arithmetic LIF model.
module tb_layer_lif_seq;

    localparam int CH  = 4;
    localparam int FIW = 2;
    localparam int NN  = 4;
    localparam int THR = 100;
    localparam int PER = FIW + 2;

    typedef struct {
        int idx;
        int volt;
        int spk;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic clear_state = 1'b0;
    logic wr_en = 1'b0;
    logic [7:0]  spikes_in = '0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    logic busy0, done0, ov0, os0, we0;
    logic busy1, done1, ov1, os1, we1;
    logic [1:0] oi0, oi1;
    logic signed [15:0] vo0, vo1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int f_s = -100;
    int wrerr_cyc = -100;
    int wm [8][4];
    int mv [2][NN];
    int lk_tab [2] = '{0, 2048};
    exp_t q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_lif_seq #(.CH(4), .WEIGHT(8), .FAN_IN_WORDS(2), .NEURON(4), .WIDTH(16),
                    .LEAK(0), .THRESHOLD(100)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .spikes_in(spikes_in), .clear_state(clear_state),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(we0), .busy(busy0),
        .done(done0), .out_valid(ov0), .out_spike(os0), .out_idx(oi0), .out_voltage(vo0));

    layer_lif_seq #(.CH(4), .WEIGHT(8), .FAN_IN_WORDS(2), .NEURON(4), .WIDTH(16),
                    .LEAK(2048), .THRESHOLD(100)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .spikes_in(spikes_in), .clear_state(clear_state),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(we1), .busy(busy1),
        .done(done1), .out_valid(ov1), .out_spike(os1), .out_idx(oi1), .out_voltage(vo1));

    task automatic chk(input string nm, input int d, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, d, cyc, got, exp);
        end
    endtask

    // Monitor: per-cycle control checks plus scoreboard pop on out_valid
    task automatic check_dut(input int d, input logic b, input logic dn, input logic v,
                             input logic s, input logic e, input logic [1:0] i,
                             input logic signed [15:0] vo);
        exp_t h;
        bit in_f;
        if (!rst) begin
            chk("reset_outputs", d, {b, dn, v, s, e, i, vo}, 0);
            return;
        end
        in_f = (f_s >= 0) && (cyc >= f_s) && (cyc <= f_s + 4*PER);
        chk("busy", d, b, in_f);
        chk("done", d, dn, (f_s >= 0) && (cyc == f_s + 4*PER));
        chk("wr_err", d, e, cyc == wrerr_cyc);
        while (q[d].size() > 0 && q[d][0].cyc < cyc) begin
            h = q[d].pop_front();
            chk("out_valid_cycle", d, cyc, h.cyc);
        end
        if (v) begin
            if (q[d].size() == 0) begin
                chk("unexpected_out_valid", d, v, 0);
            end else begin
                h = q[d].pop_front();
                chk("out_valid_cycle", d, cyc, h.cyc);
                chk("out_idx", d, i, h.idx);
                chk("out_voltage", d, vo, h.volt);
                chk("out_spike", d, s, h.spk);
            end
        end
    endtask

    always @(posedge clk) begin
        #3;
        check_dut(0, busy0, done0, ov0, os0, we0, oi0, vo0);
        check_dut(1, busy1, done1, ov1, os1, we1, oi1, vo1);
    end

    // Reference model: integrate, leak, clamp and fire with plain integer arithmetic
    task automatic predict(input logic [7:0] spk);
        exp_t e;
        int acc, vv, vn;
        for (int n = 0; n < NN; n++) begin
            acc = 0;
            for (int w = 0; w < FIW; w++)
                for (int k = 0; k < CH; k++)
                    if (spk[w*CH + k]) acc += wm[n*FIW + w][k];
            for (int d = 0; d < 2; d++) begin
                vv = mv[d][n];
                vn = vv - ((vv * lk_tab[d]) >>> 12) + acc;
                if (vn > 32767)  vn = 32767;
                if (vn < -32768) vn = -32768;
                e.idx  = n;
                e.volt = vn;
                e.spk  = (vn >= THR) ? 1 : 0;
                e.cyc  = f_s + (n + 1) * PER - 1;
                q[d].push_back(e);
                mv[d][n] = e.spk ? 0 : vn;
            end
        end
    endtask

    task automatic zero_model();
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < NN; n++) mv[d][n] = 0;
    endtask

    task automatic wr_word(input int a, input logic [31:0] dat);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = dat;
        for (int k = 0; k < CH; k++) wm[a][k] = $signed(dat[k*8 +: 8]);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_all(input int val, input bit rnd);
        logic [31:0] dat;
        for (int a = 0; a < 8; a++) begin
            for (int k = 0; k < CH; k++)
                dat[k*8 +: 8] = rnd ? 8'($urandom_range(0, 255)) : 8'(val);
            wr_word(a, dat);
        end
    endtask

    // One frame; inject adds a busy write at cycle 3 and a start+clear at cycle 5
    task automatic run_frame(input logic [7:0] spk, input bit clr, input bit inject,
                             input logic [31:0] inj_dat);
        @(negedge clk);
        if (clr) zero_model();
        start       = 1'b1;
        clear_state = clr;
        spikes_in   = spk;
        f_s         = cyc + 1;
        predict(spk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start       = 1'b0;
            clear_state = 1'b0;
            wr_en       = 1'b0;
            spikes_in   = 8'($urandom);
            if (inject && cyc == f_s + 2) begin
                wr_en     = 1'b1;
                wr_addr   = 3'd0;
                wr_data   = inj_dat;
                wrerr_cyc = f_s + 3;
            end
            if (inject && cyc == f_s + 4) begin
                start       = 1'b1;
                clear_state = 1'b1;
            end
        end
        chk("frame_drained", 0, q[0].size(), 0);
        chk("frame_drained", 1, q[1].size(), 0);
    endtask

    task automatic abort_frame(input logic [7:0] spk);
        @(negedge clk);
        start     = 1'b1;
        spikes_in = spk;
        f_s       = cyc + 1;
        predict(spk);
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst       = 1'b0;
        f_s       = -100;
        wrerr_cyc = -100;
        q[0].delete();
        q[1].delete();
        zero_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        zero_model();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Integration, firing, leak, write protection
        write_all(10, 1'b0);
        run_frame(8'hFF, 1'b1, 1'b0, '0);
        run_frame(8'hFF, 1'b0, 1'b1, {4{8'd50}});
        run_frame(8'hFF, 1'b1, 1'b0, '0);
        run_frame(8'h00, 1'b0, 1'b0, '0);
        wr_word(0, {4{8'd50}});
        run_frame(8'hFF, 1'b1, 1'b0, '0);

        // Negative saturation
        write_all(-128, 1'b0);
        run_frame(8'hFF, 1'b1, 1'b0, '0);
        for (int f = 1; f < 34; f++) run_frame(8'hFF, 1'b0, 1'b0, '0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            if (f % 5 == 0) write_all(0, 1'b1);
            run_frame(8'($urandom), ($urandom_range(0, 3) == 0), 1'b0, '0);
        end

        // Reset mid-frame, then weights must survive and voltages restart at 0
        write_all(0, 1'b1);
        run_frame(8'hFF, 1'b1, 1'b0, '0);
        abort_frame(8'hFF);
        run_frame(8'hFF, 1'b0, 1'b0, '0);
        run_frame(8'($urandom), 1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
